// File: rtl/neander_pkg.sv
// Shared definitions for the Neander SPI memory bridge: FSM states, SPI SRAM
// command bytes and frame geometry.
package neander_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } bridge_state_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
  localparam int         FRAME_BITS    = 32;
  localparam int         RX_FIRST_BIT  = FRAME_BITS - 8;

  // Complete outgoing frame: command, 16-bit address, data (zero on reads).
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       is_read,
                                                        input logic [7:0] addr,
                                                        input logic [7:0] wdata);
    return {is_read ? SPI_CMD_READ : SPI_CMD_WRITE, 8'h00, addr,
            is_read ? 8'h00 : wdata};
  endfunction

endpackage

// File: rtl/neander_spi_shifter.sv
// SPI mode-0 frame engine: SCK divider, bit counter, transmit/receive shift
// registers. Runs only while 'active' is high; 'load' arms a new frame.
module neander_spi_shifter
  import neander_pkg::*;
#(
  parameter int SCK_HALF = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  active,
  input  logic                  spi_miso,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  output logic                  frame_done,
  output logic [7:0]            rx_byte
);

  localparam logic [3:0] HALF_LAST = 4'(SCK_HALF - 1);
  localparam logic [5:0] BIT_LAST  = 6'(FRAME_BITS - 1);
  localparam logic [5:0] BIT_RX    = 6'(RX_FIRST_BIT);

  logic [FRAME_BITS-1:0] tx_reg;
  logic [6:0]            rx_reg;
  logic [5:0]            bit_reg;
  logic [3:0]            div_reg;
  logic                  phase_reg;
  logic                  half_end;
  logic                  bit_end;

  assign half_end   = active && (div_reg == HALF_LAST);
  assign bit_end    = half_end && phase_reg;
  assign frame_done = bit_end && (bit_reg == BIT_LAST);
  assign rx_byte    = {rx_reg, spi_miso};
  assign spi_sck    = active && phase_reg;
  assign spi_mosi   = active && tx_reg[FRAME_BITS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_reg    <= '0;
      rx_reg    <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (load) begin
      tx_reg    <= frame;
      rx_reg    <= '0;
      bit_reg   <= '0;
      div_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        div_reg   <= '0;
        phase_reg <= ~phase_reg;
        // MOSI advances and MISO is captured as the high half closes.
        if (phase_reg) begin
          tx_reg  <= {tx_reg[FRAME_BITS-2:0], 1'b0};
          bit_reg <= bit_reg + 6'd1;
          if (bit_reg >= BIT_RX) begin
            rx_reg <= rx_byte[6:0];
          end
        end
      end else begin
        div_reg <= div_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/neander_spi_mem_bridge.sv
// Bridges Neander CPU memory requests to an external SPI SRAM using one
// 32-bit read/write frame per access; control FSM lives here.
module neander_spi_mem_bridge
  import neander_pkg::*;
#(
  parameter int SCK_HALF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_read,
  input  logic       req_write,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ready,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  bridge_state_t state_reg;
  bridge_state_t state_next;
  logic          is_read_reg;
  logic [7:0]    rdata_reg;
  logic          start;
  logic          active;
  logic          frame_done;
  logic [7:0]    rx_byte;

  // addr/wdata are captured into the shifter's frame register at start.
  assign start  = (state_reg == ST_IDLE) && (req_read || req_write);
  assign active = (state_reg == ST_SHIFT);

  neander_spi_shifter #(
    .SCK_HALF(SCK_HALF)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (start),
    .frame     (build_frame(req_read, addr, wdata)),
    .active    (active),
    .spi_miso  (spi_miso),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .frame_done(frame_done),
    .rx_byte   (rx_byte)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req_read || req_write) state_next = ST_SHIFT;
      ST_SHIFT: if (frame_done) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      is_read_reg <= 1'b0;
      rdata_reg   <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (start) begin
        is_read_reg <= req_read;
      end
      if (active && frame_done && is_read_reg) begin
        rdata_reg <= rx_byte;
      end
    end
  end

  assign rdata    = rdata_reg;
  assign ready    = (state_reg == ST_DONE);
  assign busy     = (state_reg != ST_IDLE);
  assign spi_cs_n = ~active;

endmodule

// File: tb/tb_neander_spi_mem_bridge.sv
// Self-checking bench: lane 0 runs SCK_HALF=1, lane 1 runs SCK_HALF=3, each
// against a behavioural SPI SRAM; table vectors, corner sequences, random ops.
module tb_neander_spi_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      reset_l, req_read_l, req_write_l, miso_w;
  logic [1:0][7:0] addr_l, wdata_l, rdata_w;
  logic [1:0]      ready_w, busy_w, cs_n_w, sck_w, mosi_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    neander_spi_mem_bridge #(
      .SCK_HALF(gi == 0 ? 1 : 3)
    ) dut (
      .clk      (clk),
      .reset    (reset_l[gi]),
      .req_read (req_read_l[gi]),
      .req_write(req_write_l[gi]),
      .addr     (addr_l[gi]),
      .wdata    (wdata_l[gi]),
      .rdata    (rdata_w[gi]),
      .ready    (ready_w[gi]),
      .busy     (busy_w[gi]),
      .spi_cs_n (cs_n_w[gi]),
      .spi_sck  (sck_w[gi]),
      .spi_mosi (mosi_w[gi]),
      .spi_miso (miso_w[gi])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] preload_val(input int i);
    if (i == 16) return 8'h5A;
    if (i == 32) return 8'hC3;
    return 8'(i * 7 + 3);
  endfunction

  // SPI SRAM model and bus monitor (sole owner of these variables).
  logic [7:0]  sram_mem [2][256];
  logic [31:0] last_frame [2];
  int          frames_cnt [2], starts_cnt [2], ready_cnt [2], cs_low_len [2];
  int          sck_min [2], sck_max [2], idle_viol [2];

  initial begin
    int cnt [2], run [2], cs_len [2];
    logic [31:0] sh [2];
    logic [7:0] cmd_cap [2], addr_cap [2];
    logic prev_cs [2], prev_sck [2];
    logic cs, sck;
    miso_w = 2'b00;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) sram_mem[i][a] = preload_val(a);
      frames_cnt[i] = 0; starts_cnt[i] = 0; ready_cnt[i] = 0; cs_low_len[i] = 0;
      sck_min[i] = 0; sck_max[i] = 0; idle_viol[i] = 0;
      cnt[i] = 0; run[i] = 0; cs_len[i] = 0; sh[i] = '0; cmd_cap[i] = '0; addr_cap[i] = '0;
      prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; last_frame[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        cs = cs_n_w[i];
        sck = sck_w[i];
        if (cs && (sck || mosi_w[i])) idle_viol[i]++;
        if (!cs) begin
          if (prev_cs[i]) begin
            starts_cnt[i]++; cnt[i] = 0; cs_len[i] = 0; run[i] = 0;
            sck_min[i] = 1000; sck_max[i] = 0;
          end
          cs_len[i]++;
          if (!prev_cs[i] && sck != prev_sck[i]) begin
            if (run[i] < sck_min[i]) sck_min[i] = run[i];
            if (run[i] > sck_max[i]) sck_max[i] = run[i];
            run[i] = 1;
          end else begin
            run[i]++;
          end
          if (sck && !prev_sck[i] && !prev_cs[i]) begin
            sh[i] = {sh[i][30:0], mosi_w[i]};
            cnt[i]++;
            if (cnt[i] == 24) begin cmd_cap[i] = sh[i][23:16]; addr_cap[i] = sh[i][7:0]; end
          end
          if (!sck && prev_sck[i] && !prev_cs[i] && cnt[i] >= 24 && cnt[i] < 32 && cmd_cap[i] == 8'h03)
            miso_w[i] = sram_mem[i][addr_cap[i]][31 - cnt[i]];
        end else if (!prev_cs[i]) begin
          if (run[i] < sck_min[i]) sck_min[i] = run[i];
          if (run[i] > sck_max[i]) sck_max[i] = run[i];
          cs_low_len[i] = cs_len[i];
          miso_w[i] = 1'b0;
          if (cnt[i] == 32) begin
            frames_cnt[i]++;
            last_frame[i] = sh[i];
            if (sh[i][31:24] == 8'h02) sram_mem[i][sh[i][15:8]] = sh[i][7:0];
          end
        end
        if (ready_w[i]) ready_cnt[i]++;
        prev_cs[i] = cs;
        prev_sck[i] = sck;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request; returns cycles from sampling edge to ready (-1 on timeout).
  task automatic run_txn(input int ln, input logic rd, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input int intrude, output int lat,
                         output logic [7:0] rd_at_ready);
    @(negedge clk);
    req_read_l[ln] = rd; req_write_l[ln] = wr; addr_l[ln] = a; wdata_l[ln] = d;
    lat = 0;
    rd_at_ready = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        req_read_l[ln] = 1'b0; req_write_l[ln] = 1'b0; addr_l[ln] = 8'hEE; wdata_l[ln] = 8'h11;
      end
      if (lat == intrude) begin req_read_l[ln] = 1'b1; addr_l[ln] = a ^ 8'h40; end
      if (lat == intrude + 1) req_read_l[ln] = 1'b0;
      if (ready_w[ln]) begin rd_at_ready = rdata_w[ln]; break; end
    end
    if (!ready_w[ln]) lat = -1;
    req_read_l[ln] = 1'b0;
    @(negedge clk);
  endtask

  task automatic txn_check(input string name, input int ln, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [7:0] d, input int intrude,
                           input logic [31:0] exp_frame, input logic [7:0] exp_rdata);
    int lat, f0, r0, s0, h;
    logic [7:0] got;
    h = (ln == 0) ? 1 : 3;
    f0 = frames_cnt[ln]; r0 = ready_cnt[ln]; s0 = starts_cnt[ln];
    run_txn(ln, rd, wr, a, d, intrude, lat, got);
    check({name, ".latency"}, lat, 64 * h + 1);
    check({name, ".rdata"}, {24'h0, got}, {24'h0, exp_rdata});
    check({name, ".frame"}, last_frame[ln], exp_frame);
    check({name, ".frames"}, frames_cnt[ln] - f0, 1);
    check({name, ".starts"}, starts_cnt[ln] - s0, 1);
    check({name, ".readys"}, ready_cnt[ln] - r0, 1);
    check({name, ".cs_low"}, cs_low_len[ln], 64 * h);
    check({name, ".busy_idle"}, {31'h0, busy_w[ln]}, 0);
    $display("txn %s lane%0d rd=%0b wr=%0b addr=%h wdata=%h frame=%h rdata=%h lat=%0d",
             name, ln, rd, wr, a, d, last_frame[ln], got, lat);
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [31:0] frame;
    logic [7:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t vecs [8];
    logic [7:0] ref_mem [256];
    logic [7:0] cur_rdata, exp_rd, ra, rdv;
    logic rrd, rwr;
    int f0, r0, diffs;

    vecs[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 32'h02003CA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h77, 32'h03001000, 8'h5A};
    vecs[2] = '{1'b1, 1'b1, 8'h20, 8'hFF, 32'h03002000, 8'hC3};
    vecs[3] = '{1'b1, 1'b0, 8'h3C, 8'h00, 32'h03003C00, 8'hA5};
    vecs[4] = '{1'b0, 1'b1, 8'h10, 8'h00, 32'h02001000, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 8'h99, 32'h03001000, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'h81, 32'h0200FF81, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'hFF, 8'h00, 32'h0300FF00, 8'h81};
    for (int a = 0; a < 256; a++) ref_mem[a] = preload_val(a);

    reset_l = 2'b11; req_read_l = '0; req_write_l = '0; addr_l = '0; wdata_l = '0;
    repeat (4) @(negedge clk);
    for (int ln = 0; ln < 2; ln++) begin
      check($sformatf("reset%0d.outs", ln),
            {26'h0, cs_n_w[ln], sck_w[ln], mosi_w[ln], ready_w[ln], busy_w[ln], 1'b0}, 32'h20);
      check($sformatf("reset%0d.rdata", ln), {24'h0, rdata_w[ln]}, 0);
    end
    reset_l = 2'b00;
    cur_rdata = 8'h00;

    foreach (vecs[i]) begin
      txn_check($sformatf("vec%0d", i), 0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 0,
                vecs[i].frame, vecs[i].exp_rdata);
      if (!vecs[i].rd) ref_mem[vecs[i].a] = vecs[i].d;
      cur_rdata = vecs[i].exp_rdata;
    end
    check("priority.no_write", {24'h0, sram_mem[0][8'h20]}, 32'hC3);

    // A read request arriving mid-frame must be dropped, not queued.
    txn_check("busy_ignore", 0, 1'b0, 1'b1, 8'h44, 8'h3E, 10, 32'h0200443E, cur_rdata);
    ref_mem[8'h44] = 8'h3E;
    f0 = starts_cnt[0];
    repeat (5) @(negedge clk);
    check("busy_ignore.no_restart", starts_cnt[0] - f0, 0);

    // Reset 30 cycles into a read: abort with no ready pulse.
    f0 = frames_cnt[0]; r0 = ready_cnt[0];
    @(negedge clk);
    req_read_l[0] = 1'b1; addr_l[0] = 8'h3C;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) req_read_l[0] = 1'b0;
    end
    check("abort.mid_shift", {31'h0, cs_n_w[0]}, 0);
    reset_l[0] = 1'b1;
    @(negedge clk);
    check("abort.outs", {27'h0, cs_n_w[0], sck_w[0], busy_w[0], ready_w[0], mosi_w[0]}, 32'h10);
    check("abort.rdata", {24'h0, rdata_w[0]}, 0);
    reset_l[0] = 1'b0;
    repeat (80) @(negedge clk);
    check("abort.no_ready", ready_cnt[0] - r0, 0);
    check("abort.no_frame", frames_cnt[0] - f0, 0);
    $display("txn abort lane0 read addr=3c rdata=%h", rdata_w[0]);
    cur_rdata = 8'h00;

    for (int n = 0; n < 30; n++) begin
      int k;
      k = $urandom_range(0, 2);
      rrd = (k != 1);
      rwr = (k != 0);
      ra = 8'($urandom_range(0, 255));
      rdv = 8'($urandom_range(0, 255));
      exp_rd = rrd ? ref_mem[ra] : cur_rdata;
      txn_check($sformatf("rand%0d", n), 0, rrd, rwr, ra, rdv, 0,
                {rrd ? 8'h03 : 8'h02, 8'h00, ra, rrd ? 8'h00 : rdv}, exp_rd);
      if (!rrd) ref_mem[ra] = rdv;
      cur_rdata = exp_rd;
    end

    txn_check("div3_read", 1, 1'b1, 1'b0, 8'h10, 8'h00, 0, 32'h03001000, 8'h5A);
    check("div3.sck_min", sck_min[1], 3);
    check("div3.sck_max", sck_max[1], 3);

    diffs = 0;
    for (int a = 0; a < 256; a++) if (sram_mem[0][a] !== ref_mem[a]) diffs++;
    check("mem.contents", diffs, 0);
    check("idle0.quiet", idle_viol[0], 0);
    check("idle1.quiet", idle_viol[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
